jace_sram_slot_arbiter: RTL and testbench

- Time-division arbiter that shares the external SRAM byte port between the Jupiter ACE core and a secondary loader requester, such as an SD/tape-image DMA.
- It sits between the core's ext_sram_* signals and the wrapper's sram_*_in inputs, and drives that bus on the core's behalf.
- Each 4-cycle clkram frame gives phases 0-1 to the core, which has fixed timing and no wait states. Phases 2-3 go to the loader, which uses a req/ack handshake.

---
 rtl/jace_sram_slot_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_jace_sram_slot_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jace_sram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// jace_sram_slot_arbiter
//
// Purpose:
//   Time-division arbiter for the external SRAM byte port. The port is shared
//   between the Jupiter ACE core and a secondary loader requester, such as an
//   SD or tape-image DMA. Each 4-cycle clkram frame is split into two slots:
//     phase 0-1 : core slot. The timing is fixed and there are no wait states.
//                 Address and data are launched at the end of phase 3. The
//                 write strobe is low only in phase 1. Read data is captured
//                 at the end of phase 1.
//     phase 2-3 : loader slot. Requests use a req/ack handshake. Address and
//                 data are launched at the end of phase 1. The write strobe is
//                 low only in phase 3. Read data is captured at the end of
//                 phase 3. The ack pulse follows in phase 0.
//   Every sram_* output comes straight from a flop, so no input reaches the
//   SRAM bus combinationally.
//
// Ports:
//   clkram      in   26 MHz clock (4x clk65). Phase 0 starts on clk65 rise.
//   reset_n     in   asynchronous active-low reset
//   core_*      in   core address, write strobe, read enable and write data.
//                    These must be stable at the edge that ends phase 3.
//   core_rdata  out  last core read data, stable from phase 2 to phase 1
//   ldr_req     in   loader request, with op (ldr_we), address and data
//   ldr_ack     out  one-cycle completion pulse, high during phase 0
//   ldr_rdata   out  loader read data, valid from ack onward
//   ldr_busy    out  a request is latched and not yet completed
//   sram_*      out  registered bus to the wrapper sram_*_in pins
//   sram_rdata  in   data from the wrapper sram_data_from_chip
//   phase       out  current slot phase
// ---------------------------------------------------------------------------
module jace_sram_slot_arbiter #(
    parameter int            AW      = 21,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] RD_IDLE = 8'hFF
) (
    input  logic          clkram,
    input  logic          reset_n,
    // core side
    input  logic [AW-1:0] core_addr,
    input  logic          core_we_n,
    input  logic          core_oe_n,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    // loader side
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_busy,
    // SRAM wrapper side
    output logic [AW-1:0] sram_addr,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    // debug
    output logic [1:0]    phase
);

    // Each phase is named after the edge that ends it.
    typedef enum logic [1:0] {
        PH_CORE_SETUP  = 2'd0,  // ends: core write strobe asserted
        PH_CORE_STROBE = 2'd1,  // ends: core read captured, loader slot launched
        PH_LDR_SETUP   = 2'd2,  // ends: loader write strobe asserted
        PH_LDR_STROBE  = 2'd3   // ends: loader completes, core slot launched
    } phase_e;

    phase_e        phase_q, phase_d;

    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [DW-1:0] sram_wdata_q, sram_wdata_d;
    logic          sram_we_n_q, sram_we_n_d;
    logic          sram_oe_n_q, sram_oe_n_d;

    logic          core_we_n_q, core_we_n_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;

    logic          ldr_we_q, ldr_we_d;
    logic [AW-1:0] ldr_addr_q, ldr_addr_d;
    logic [DW-1:0] ldr_wdata_q, ldr_wdata_d;
    logic          ldr_busy_q, ldr_busy_d;
    logic          ldr_slot_q, ldr_slot_d;  // loader owns the current phase 2-3
    logic          ldr_ack_q, ldr_ack_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

    logic          ldr_accept;

    // Busy is low only between requests. It is also low during the ack cycle,
    // because busy drops together with the rising ack. That lets a requester
    // that holds ldr_req high be re-accepted on the ack cycle, which sustains
    // one access per frame.
    assign ldr_accept = ldr_req & ~ldr_busy_q;

    // NOTE: every *_d gets a default first so that no path through the case
    // leaves a signal unassigned. Otherwise a latch would be inferred.
    always_comb begin
        phase_d      = phase_e'(phase_q + 2'd1);
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = sram_we_n_q;
        sram_oe_n_d  = sram_oe_n_q;
        core_we_n_d  = core_we_n_q;
        core_rdata_d = core_rdata_q;
        ldr_we_d     = ldr_we_q;
        ldr_addr_d   = ldr_addr_q;
        ldr_wdata_d  = ldr_wdata_q;
        ldr_busy_d   = ldr_busy_q;
        ldr_slot_d   = ldr_slot_q;
        ldr_ack_d    = 1'b0;
        ldr_rdata_d  = ldr_rdata_q;

        // Latch the request once. Later changes to the inputs are ignored.
        if (ldr_accept) begin
            ldr_we_d    = ldr_we;
            ldr_addr_d  = ldr_addr;
            ldr_wdata_d = ldr_wdata;
            ldr_busy_d  = 1'b1;
        end

        case (phase_q)
            PH_CORE_SETUP: begin
                // Address and data have been stable for one cycle by now.
                sram_we_n_d = core_we_n_q;
            end
            PH_CORE_STROBE: begin
                // oe is still the core's value here. The loader has not
                // launched yet.
                if (!sram_oe_n_q) begin
                    core_rdata_d = sram_rdata;
                end
                // A request accepted at this same edge waits for the next
                // frame, which is why the worst-case latency is 7 cycles.
                if (ldr_busy_q) begin
                    ldr_slot_d   = 1'b1;
                    sram_addr_d  = ldr_addr_q;
                    sram_wdata_d = ldr_wdata_q;
                    sram_oe_n_d  = ldr_we_q;
                    sram_we_n_d  = 1'b1;
                end else begin
                    sram_oe_n_d  = 1'b1;
                    sram_we_n_d  = 1'b1;
                end
            end
            PH_LDR_SETUP: begin
                if (ldr_slot_q) begin
                    sram_we_n_d = ~ldr_we_q;
                end
            end
            PH_LDR_STROBE: begin
                if (ldr_slot_q) begin
                    if (!ldr_we_q) begin
                        ldr_rdata_d = sram_rdata;
                    end
                    ldr_ack_d  = 1'b1;
                    ldr_busy_d = 1'b0;
                    ldr_slot_d = 1'b0;
                end
                // Launch the core slot. oe is suppressed on a write so that the
                // bus is never driven from both sides.
                sram_addr_d  = core_addr;
                sram_wdata_d = core_wdata;
                sram_oe_n_d  = core_oe_n | ~core_we_n;
                sram_we_n_d  = 1'b1;
                core_we_n_d  = core_we_n;
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so that every flop
    // samples the pre-edge values, whatever the order of the statements.
    always_ff @(posedge clkram or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= PH_CORE_SETUP;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            core_we_n_q  <= 1'b1;
            core_rdata_q <= RD_IDLE;
            ldr_we_q     <= 1'b0;
            ldr_addr_q   <= '0;
            ldr_wdata_q  <= '0;
            ldr_busy_q   <= 1'b0;
            ldr_slot_q   <= 1'b0;
            ldr_ack_q    <= 1'b0;
            ldr_rdata_q  <= RD_IDLE;
        end else begin
            phase_q      <= phase_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            core_we_n_q  <= core_we_n_d;
            core_rdata_q <= core_rdata_d;
            ldr_we_q     <= ldr_we_d;
            ldr_addr_q   <= ldr_addr_d;
            ldr_wdata_q  <= ldr_wdata_d;
            ldr_busy_q   <= ldr_busy_d;
            ldr_slot_q   <= ldr_slot_d;
            ldr_ack_q    <= ldr_ack_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    assign phase      = phase_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign core_rdata = core_rdata_q;
    assign ldr_ack    = ldr_ack_q;
    assign ldr_busy   = ldr_busy_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_jace_sram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jace_sram_slot_arbiter
//
// Directed bench for jace_sram_slot_arbiter. It uses a simple byte-wide SRAM
// model. Inputs are driven and outputs sampled on the falling edge, half a
// cycle away from the active rising edge. exp_ph is the bench's own count of
// the slot phase, reset asynchronously just like the design.
// ---------------------------------------------------------------------------
module tb_jace_sram_slot_arbiter;

    localparam int AW = 21;
    localparam int DW = 8;

    logic          clkram;
    logic          reset_n;
    logic [AW-1:0] core_addr;
    logic          core_we_n;
    logic          core_oe_n;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_busy;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [1:0]    phase;

    int n_total = 0;
    int n_bad   = 0;

    logic [1:0] exp_ph;
    logic [7:0] mem [0:65535];

    jace_sram_slot_arbiter #(.AW(AW), .DW(DW), .RD_IDLE(8'hFF)) dut (
        .clkram     (clkram),
        .reset_n    (reset_n),
        .core_addr  (core_addr),
        .core_we_n  (core_we_n),
        .core_oe_n  (core_oe_n),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_ack    (ldr_ack),
        .ldr_rdata  (ldr_rdata),
        .ldr_busy   (ldr_busy),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .phase      (phase)
    );

    initial clkram = 1'b0;
    always #5 clkram = ~clkram;

    // SRAM model: combinational read while oe is low, and a write on the
    // clock edge that ends a cycle with we low.
    assign sram_rdata = sram_oe_n ? 8'h00 : mem[sram_addr[15:0]];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h2400] = 8'h5A;
        mem[16'h2410] = 8'hA5;
    end

    always @(posedge clkram) begin
        if (!sram_we_n) mem[sram_addr[15:0]] = sram_wdata;
    end

    always @(posedge clkram or negedge reset_n) begin
        if (!reset_n) exp_ph <= 2'd0;
        else          exp_ph <= exp_ph + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clkram);
    endtask

    // Advance to the falling edge inside the requested phase. This takes at
    // most 4 cycles.
    task automatic go_to_phase(input logic [1:0] p);
        for (int i = 0; i < 5; i++) begin
            if (exp_ph == p) break;
            step();
        end
    endtask

    task automatic core_idle();
        core_we_n  = 1'b1;
        core_oe_n  = 1'b1;
        core_addr  = '0;
        core_wdata = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phase"},  32'(phase),      32'h0);
        check({tag, "_we_n"},   32'(sram_we_n),  32'h1);
        check({tag, "_oe_n"},   32'(sram_oe_n),  32'h1);
        check({tag, "_addr"},   32'(sram_addr),  32'h0);
        check({tag, "_wdata"},  32'(sram_wdata), 32'h0);
        check({tag, "_crdata"}, 32'(core_rdata), 32'hFF);
        check({tag, "_lrdata"}, 32'(ldr_rdata),  32'hFF);
        check({tag, "_ack"},    32'(ldr_ack),    32'h0);
        check({tag, "_busy"},   32'(ldr_busy),   32'h0);
    endtask

    initial begin
        logic [1:0] ph_seq [0:4];
        int lat;

        ph_seq[0] = 2'd0; ph_seq[1] = 2'd1; ph_seq[2] = 2'd2;
        ph_seq[3] = 2'd3; ph_seq[4] = 2'd0;

        reset_n   = 1'b0;
        core_idle();
        ldr_req   = 1'b0;
        ldr_we    = 1'b0;
        ldr_addr  = '0;
        ldr_wdata = '0;

        // ---------------- reset and phase sequence ----------------
        repeat (3) step();
        check_reset_values("rst");
        @(posedge clkram);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("ph_seq%0d", k), 32'(phase), 32'(ph_seq[k]));
            check($sformatf("idle_we%0d", k), 32'(sram_we_n), 32'h1);
            check($sformatf("idle_oe%0d", k), 32'(sram_oe_n), 32'h1);
        end
        check("idle_crdata", 32'(core_rdata), 32'hFF);

        // ---------------- core read of 0x02400 ----------------
        go_to_phase(2'd3);
        core_addr = 21'h02400;
        core_oe_n = 1'b0;
        core_we_n = 1'b1;
        step();                                   // phase 0
        core_idle();
        check("crd_p0_addr", 32'(sram_addr), 32'h02400);
        check("crd_p0_oe",   32'(sram_oe_n), 32'h0);
        check("crd_p0_we",   32'(sram_we_n), 32'h1);
        step();                                   // phase 1
        check("crd_p1_oe",   32'(sram_oe_n), 32'h0);
        check("crd_p1_we",   32'(sram_we_n), 32'h1);
        check("crd_p1_data", 32'(core_rdata), 32'hFF);
        step();                                   // phase 2
        check("crd_p2_data", 32'(core_rdata), 32'h5A);
        check("crd_p2_oe",   32'(sram_oe_n), 32'h1);
        go_to_phase(2'd1);                        // next frame, idle core
        check("crd_hold",    32'(core_rdata), 32'h5A);

        // ---------------- core write 0xC3 to 0x03000 ----------------
        go_to_phase(2'd3);
        core_addr  = 21'h03000;
        core_wdata = 8'hC3;
        core_we_n  = 1'b0;
        core_oe_n  = 1'b1;
        step();                                   // phase 0
        core_idle();
        check("cwr_p0_we",    32'(sram_we_n),  32'h1);
        check("cwr_p0_oe",    32'(sram_oe_n),  32'h1);
        check("cwr_p0_wdata", 32'(sram_wdata), 32'hC3);
        check("cwr_p0_addr",  32'(sram_addr),  32'h03000);
        step();                                   // phase 1
        check("cwr_p1_we",    32'(sram_we_n),  32'h0);
        step();                                   // phase 2
        check("cwr_p2_we",    32'(sram_we_n),  32'h1);
        check("cwr_mem",      32'(mem[16'h3000]), 32'hC3);
        check("cwr_crdata",   32'(core_rdata), 32'h5A);

        // ---------------- loader write accepted at end of phase 0 ----------------
        go_to_phase(2'd0);
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 21'h0C000;
        ldr_wdata = 8'h77;
        step();                                   // phase 1, cycle 1
        check("lwr_busy", 32'(ldr_busy), 32'h1);
        ldr_req   = 1'b0;
        ldr_addr  = 21'h00001;                    // must be ignored
        ldr_wdata = 8'h11;
        step();                                   // phase 2, cycle 2
        check("lwr_p2_addr",  32'(sram_addr),  32'h0C000);
        check("lwr_p2_wdata", 32'(sram_wdata), 32'h77);
        check("lwr_p2_oe",    32'(sram_oe_n),  32'h1);
        check("lwr_p2_we",    32'(sram_we_n),  32'h1);
        step();                                   // phase 3, cycle 3
        check("lwr_p3_we",    32'(sram_we_n),  32'h0);
        check("lwr_p3_ack",   32'(ldr_ack),    32'h0);
        core_addr = 21'h02410;                    // concurrent core read
        core_oe_n = 1'b0;
        step();                                   // phase 0, cycle 4
        core_idle();
        check("lwr_ack",      32'(ldr_ack),    32'h1);
        check("lwr_busy_clr", 32'(ldr_busy),   32'h0);
        check("lwr_core_addr", 32'(sram_addr), 32'h02410);
        check("lwr_core_oe",  32'(sram_oe_n),  32'h0);
        step();                                   // phase 1
        check("lwr_ack_pulse", 32'(ldr_ack),   32'h0);
        step();                                   // phase 2
        check("lwr_core_rd",  32'(core_rdata), 32'hA5);
        check("lwr_mem",      32'(mem[16'hC000]), 32'h77);
        check("lwr_mem_bad",  32'(mem[16'h0001]), 32'h00);
        check("lwr_lrdata",   32'(ldr_rdata),  32'hFF);

        // ---------------- loader read accepted at end of phase 1, back-to-back ----------------
        go_to_phase(2'd1);
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 21'h03000;
        lat = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 5) begin
                check("lrd_p2_addr", 32'(sram_addr), 32'h03000);
                check("lrd_p2_oe",   32'(sram_oe_n), 32'h0);
            end
            if (ldr_ack && lat == 0) lat = c;
        end
        check("lrd_latency", 32'(lat), 32'd7);
        check("lrd_rdata",   32'(ldr_rdata), 32'hC3);
        ldr_addr = 21'h0C000;                     // next request, still held
        step();                                   // cycle 8, phase 1
        check("b2b_busy", 32'(ldr_busy), 32'h1);
        check("b2b_ack0", 32'(ldr_ack),  32'h0);
        repeat (3) step();                        // cycle 11, phase 0
        check("b2b_ack",   32'(ldr_ack),   32'h1);
        check("b2b_rdata", 32'(ldr_rdata), 32'h77);
        ldr_req = 1'b0;
        step();
        check("b2b_idle",  32'(ldr_busy),  32'h0);

        // ---------------- reset mid-transaction ----------------
        go_to_phase(2'd0);
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 21'h05000;
        ldr_wdata = 8'h99;
        step();                                   // phase 1
        ldr_req   = 1'b0;
        step();                                   // phase 2
        check("mrst_busy_pre", 32'(ldr_busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_values("mrst");
        repeat (3) begin
            step();
            check("mrst_hold_ack", 32'(ldr_ack), 32'h0);
        end
        @(posedge clkram);
        #1 reset_n = 1'b1;
        step();
        check("mrst_rel_phase", 32'(phase), 32'h0);
        check("mrst_no_ack",    32'(ldr_ack), 32'h0);
        check("mrst_mem",       32'(mem[16'h5000]), 32'h00);
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 21'h02400;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            ldr_req = 1'b0;
            if (ldr_ack) begin
                lat = c;
                break;
            end
        end
        check("mrst_latency", 32'(lat), 32'd4);
        check("mrst_rdata",   32'(ldr_rdata), 32'h5A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
